// File: rtl/aexm_intc_pkg.sv
// Shared register map for the aexm interrupt controller.
package aexm_intc_pkg;

  typedef enum logic [2:0] {
    REG_ISR  = 3'd0,
    REG_IER  = 3'd1,
    REG_IPR  = 3'd2,
    REG_IVR  = 3'd3,
    REG_IMR  = 3'd4,
    REG_MER  = 3'd5,
    REG_RSV6 = 3'd6,
    REG_RSV7 = 3'd7
  } regIdx_e;

  localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/aexm_intc_sync.sv
// Per-bit two-flop synchroniser for raw interrupt lines, plus a delay flop for rise detection.
module aexm_intc_sync #(
  parameter int unsigned NSRC = 8
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic [NSRC-1:0] irqRaw,
  output logic [NSRC-1:0] lvl,
  output logic [NSRC-1:0] rise
);

  logic [NSRC-1:0] meta;
  logic [NSRC-1:0] sync;
  logic [NSRC-1:0] syncDly;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta    <= '0;
      sync    <= '0;
      syncDly <= '0;
    end else begin
      meta    <= irqRaw;
      sync    <= meta;
      syncDly <= sync;
    end
  end

  assign lvl  = sync;
  assign rise = sync & ~syncDly;

endmodule

// File: rtl/aexm_intc.sv
// Interrupt controller: pending/enable/mode registers, priority vector and a level request to the core.
module aexm_intc
  import aexm_intc_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic            reg_stb,
  input  logic            reg_we,
  input  logic [2:0]      reg_adr,
  input  logic [31:0]     reg_dati,
  output logic [31:0]     reg_dato,
  output logic            reg_ack,
  output logic            sys_int_o
);

  logic [NSRC-1:0] lvl;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] isr;
  logic [NSRC-1:0] ier;
  logic [NSRC-1:0] imr;
  logic [NSRC-1:0] ipr;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] isrNext;
  logic            mer;
  logic            access;
  logic            wr;
  regIdx_e         adr;
  logic [31:0]     ivr;
  logic [31:0]     rdata;
  logic [31:0]     isrW;
  logic [31:0]     ierW;
  logic [31:0]     iprW;
  logic [31:0]     imrW;

  aexm_intc_sync #(.NSRC(NSRC)) uSync (
    .gclk   (gclk),
    .grst_n (grst_n),
    .irqRaw (irq_src),
    .lvl    (lvl),
    .rise   (rise)
  );

  assign access = reg_stb & ~reg_ack;
  assign wr     = access & reg_we;
  assign adr    = regIdx_e'(reg_adr);
  assign ipr    = isr & ier;

  // Edge bits: a new rise wins over a simultaneous clear. Level bits track the synced line.
  always_comb begin
    w1c = '0;
    if (wr && adr == REG_ISR) w1c = reg_dati[NSRC-1:0];
    isrNext = (imr & ((isr & ~w1c) | rise)) | (~imr & lvl);
  end

  always_comb begin
    ivr = IVR_NONE;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (ipr[i-1]) ivr = 32'(i - 1);
    end
  end

  always_comb begin
    isrW = '0;
    ierW = '0;
    iprW = '0;
    imrW = '0;
    isrW[NSRC-1:0] = isr;
    ierW[NSRC-1:0] = ier;
    iprW[NSRC-1:0] = ipr;
    imrW[NSRC-1:0] = imr;
    rdata = '0;
    case (adr)
      REG_ISR: rdata = isrW;
      REG_IER: rdata = ierW;
      REG_IPR: rdata = iprW;
      REG_IVR: rdata = ivr;
      REG_IMR: rdata = imrW;
      REG_MER: rdata = {31'd0, mer};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      isr       <= '0;
      ier       <= '0;
      imr       <= '0;
      mer       <= 1'b0;
      reg_ack   <= 1'b0;
      reg_dato  <= '0;
      sys_int_o <= 1'b0;
    end else begin
      isr       <= isrNext;
      reg_ack   <= access;
      sys_int_o <= mer & (|ipr);
      if (access) reg_dato <= rdata;
      if (wr) begin
        case (adr)
          REG_IER: ier <= reg_dati[NSRC-1:0];
          REG_IMR: imr <= reg_dati[NSRC-1:0];
          REG_MER: mer <= reg_dati[0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aexm_intc.sv
// Directed bench for aexm_intc; read results are checked through an expected-value queue.
module tb_aexm_intc;

  localparam int unsigned NSRC = 8;

  logic            gclk = 1'b0;
  logic            grst_n = 1'b1;
  logic [NSRC-1:0] irq_src = '0;
  logic            reg_stb = 1'b0;
  logic            reg_we = 1'b0;
  logic [2:0]      reg_adr = '0;
  logic [31:0]     reg_dati = '0;
  logic [31:0]     reg_dato;
  logic            reg_ack;
  logic            sys_int_o;

  int unsigned passCnt = 0;
  int unsigned totalCnt = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];

  aexm_intc #(.NSRC(NSRC)) dut (
    .gclk      (gclk),
    .grst_n    (grst_n),
    .irq_src   (irq_src),
    .reg_stb   (reg_stb),
    .reg_we    (reg_we),
    .reg_adr   (reg_adr),
    .reg_dati  (reg_dati),
    .reg_dato  (reg_dato),
    .reg_ack   (reg_ack),
    .sys_int_o (sys_int_o)
  );

  always #5 gclk = ~gclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    assert (got === exp) passCnt++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic waitClk(input int unsigned n);
    repeat (n) @(negedge gclk);
  endtask

  task automatic access(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                        input logic [31:0] exp, input string tag);
    logic        got;
    logic [31:0] e;
    string       t;
    @(negedge gclk);
    reg_stb  = 1'b1;
    reg_we   = we;
    reg_adr  = adr;
    reg_dati = dat;
    if (!we) begin
      expQ.push_back(exp);
      tagQ.push_back(tag);
    end
    got = 1'b0;
    for (int unsigned n = 0; n < 4 && !got; n++) begin
      @(negedge gclk);
      if (reg_ack === 1'b1) got = 1'b1;
    end
    reg_stb = 1'b0;
    reg_we  = 1'b0;
    check({tag, "_ack"}, {31'd0, got}, 32'd1);
    if (!we) begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      if (got) check(t, reg_dato, e);
    end
  endtask

  task automatic wr(input logic [2:0] adr, input logic [31:0] dat);
    access(1'b1, adr, dat, '0, "wr");
  endtask

  task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string tag);
    access(1'b0, adr, '0, exp, tag);
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    @(negedge gclk);
    irq_src = irq_src | mask;
    @(negedge gclk);
    irq_src = irq_src & ~mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passCnt, totalCnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    #2 grst_n = 1'b0;
    #1;
    check("rst_ack", {31'd0, reg_ack}, 32'd0);
    check("rst_int", {31'd0, sys_int_o}, 32'd0);
    check("rst_dato", reg_dato, 32'd0);
    waitClk(2);
    grst_n = 1'b1;
    rd(3'd0, 32'd0, "rst_isr");
    rd(3'd1, 32'd0, "rst_ier");
    rd(3'd3, 32'hFFFF_FFFF, "rst_ivr");
    rd(3'd5, 32'd0, "rst_mer");

    // Reserved registers and MER upper bits
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, 32'd0, "rsv6");
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, 32'd1, "mer_bit0");

    // Edge mode: pulse bit0
    wr(3'd4, 32'hFF);
    wr(3'd1, 32'hFF);
    pulse(8'h01);
    waitClk(2);
    check("edge_int_early", {31'd0, sys_int_o}, 32'd0);
    waitClk(1);
    check("edge_int", {31'd0, sys_int_o}, 32'd1);
    rd(3'd3, 32'd0, "edge_ivr");
    wr(3'd0, 32'h1);
    check("w1c_int_hold", {31'd0, sys_int_o}, 32'd1);
    waitClk(1);
    check("w1c_int_clr", {31'd0, sys_int_o}, 32'd0);

    // Priority
    pulse(8'h24);
    waitClk(4);
    rd(3'd3, 32'd2, "prio_ivr2");
    wr(3'd0, 32'h4);
    rd(3'd3, 32'd5, "prio_ivr5");
    wr(3'd0, 32'h20);
    rd(3'd3, 32'hFFFF_FFFF, "prio_none");

    // Level mode
    wr(3'd4, 32'h00);
    irq_src[3] = 1'b1;
    waitClk(4);
    rd(3'd0, 32'h8, "lvl_set");
    wr(3'd0, 32'h8);
    rd(3'd0, 32'h8, "lvl_w1c_ignored");
    check("lvl_int", {31'd0, sys_int_o}, 32'd1);
    irq_src[3] = 1'b0;
    waitClk(4);
    rd(3'd0, 32'h0, "lvl_drop");

    // Collision of new edge with W1C on bit1
    wr(3'd4, 32'h02);
    wr(3'd1, 32'h02);
    pulse(8'h02);
    waitClk(3);
    check("col_pre_int", {31'd0, sys_int_o}, 32'd1);
    @(negedge gclk);
    irq_src[1] = 1'b1;
    @(negedge gclk);
    irq_src[1] = 1'b0;
    @(negedge gclk);
    reg_stb = 1'b1; reg_we = 1'b1; reg_adr = 3'd0; reg_dati = 32'h2;
    @(negedge gclk);
    check("col_ack", {31'd0, reg_ack}, 32'd1);
    reg_stb = 1'b0; reg_we = 1'b0;
    waitClk(1);
    check("col_int", {31'd0, sys_int_o}, 32'd1);
    rd(3'd0, 32'h2, "col_isr");
    waitClk(3);
    wr(3'd0, 32'h2);
    rd(3'd0, 32'h0, "col_plain_clr");

    // Masking
    wr(3'd4, 32'h10);
    wr(3'd1, 32'h00);
    pulse(8'h10);
    waitClk(4);
    check("mask_int", {31'd0, sys_int_o}, 32'd0);
    rd(3'd2, 32'h0, "mask_ipr");
    rd(3'd0, 32'h10, "mask_isr");
    rd(3'd3, 32'hFFFF_FFFF, "mask_ivr");
    wr(3'd1, 32'h10);
    check("en_int_hold", {31'd0, sys_int_o}, 32'd0);
    waitClk(1);
    check("en_int", {31'd0, sys_int_o}, 32'd1);
    rd(3'd3, 32'd4, "en_ivr");
    wr(3'd5, 32'h0);
    waitClk(1);
    check("mer_off_int", {31'd0, sys_int_o}, 32'd0);

    // Reset asserted mid-access
    wr(3'd5, 32'h1);
    rd(3'd0, 32'h10, "pre_rst_isr");
    check("pre_rst_int", {31'd0, sys_int_o}, 32'd1);
    @(negedge gclk);
    reg_stb = 1'b1; reg_we = 1'b1; reg_adr = 3'd1; reg_dati = 32'hFF;
    #2 grst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'd0, reg_ack}, 32'd0);
    check("mid_rst_int", {31'd0, sys_int_o}, 32'd0);
    check("mid_rst_dato", reg_dato, 32'd0);
    @(negedge gclk);
    reg_stb = 1'b0; reg_we = 1'b0;
    grst_n = 1'b1;
    rd(3'd0, 32'd0, "post_isr");
    rd(3'd1, 32'd0, "post_ier_lost");
    rd(3'd2, 32'd0, "post_ipr");
    rd(3'd3, 32'hFFFF_FFFF, "post_ivr");
    rd(3'd4, 32'd0, "post_imr");
    rd(3'd5, 32'd0, "post_mer");
    check("scoreboard_empty", expQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
